// File: rtl/ahb_reg_slave.sv
// rtl/ahb_reg_slave.sv - AHB-Lite register-bank subordinate with wait states and two-cycle error
module ahb_reg_slave #(
  parameter int          ADDR_W      = 12,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ahb_hsel_i,
  input  logic [31:0]           ahb_haddr_i,
  input  logic                  ahb_hwrite_i,
  input  logic [2:0]            ahb_hsize_i,
  input  logic [1:0]            ahb_htrans_i,
  input  logic                  ahb_hready_i,
  input  logic [31:0]           ahb_hwdata_i,
  output logic                  ahb_hreadyout_o,
  output logic                  ahb_hresp_o,
  output logic [31:0]           ahb_hrdata_o,
  output logic [NUM_REGS*32-1:0] regs_o
);

  localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t           state;
  logic [31:0]      regs [NUM_REGS];
  logic [IDX_W-1:0] idx_q;
  logic             write_q;
  logic [2:0]       size_q;
  logic [1:0]       lane_q;
  logic [2:0]       wait_cnt;
  logic             hreadyout_q;
  logic             hresp_q;
  logic [31:0]      hrdata_q;

  logic [ADDR_W-3:0] addr_word;
  logic [IDX_W-1:0]  addr_idx;
  logic              can_accept;
  logic              accept;
  logic              bad_access;
  logic              commit;
  logic [31:0]       wr_merged;
  logic [31:0]       rd_fwd;
  logic              unused_bits;

  // Merge write data into the old word on the byte lanes selected by size/low address bits.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val, input logic [31:0] new_val,
                                               input logic [2:0] size, input logic [1:0] lane);
    logic [3:0]  be;
    logic [31:0] res;
    case (size)
      3'd0:    be = 4'b0001 << lane;
      3'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign addr_word  = ahb_haddr_i[ADDR_W-1:2];
  assign addr_idx   = addr_word[IDX_W-1:0];
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept && ahb_hsel_i && ahb_htrans_i[1] && ahb_hready_i;
  assign bad_access = (int'(addr_word) >= NUM_REGS) ||
                      (ahb_hsize_i > 3'd2) ||
                      ((ahb_hsize_i == 3'd2) && (ahb_haddr_i[1:0] != 2'b00)) ||
                      ((ahb_hsize_i == 3'd1) && ahb_haddr_i[0]);

  // A pending write commits on the final data-phase edge; a read accepted on that same
  // edge sees the merged value so write-then-read returns the new contents.
  assign commit    = (state == ST_DATA) && write_q;
  assign wr_merged = merge_lanes(regs[idx_q], ahb_hwdata_i, size_q, lane_q);
  assign rd_fwd    = (commit && (idx_q == addr_idx)) ? wr_merged : regs[addr_idx];

  assign unused_bits = ^{ahb_htrans_i[0], ahb_haddr_i[31:ADDR_W]};

  // Register bank: reset to RESET_VAL, updated only by a committing write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (commit) begin
      regs[idx_q] <= wr_merged;
    end
  end

  // Transfer FSM: latches address-phase controls and produces registered bus responses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      lane_q      <= 2'd0;
      wait_cnt    <= 3'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'h0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state       <= ST_DATA;
            hreadyout_q <= 1'b1;
            hrdata_q    <= write_q ? 32'h0 : regs[idx_q];
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (accept) begin
            idx_q   <= addr_idx;
            write_q <= ahb_hwrite_i;
            size_q  <= ahb_hsize_i;
            lane_q  <= ahb_haddr_i[1:0];
            if (bad_access) begin
              state       <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
              hrdata_q    <= 32'h0;
            end else if (WAIT_STATES > 0) begin
              state       <= ST_WAIT;
              wait_cnt    <= WS_LOAD;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
              hrdata_q    <= 32'h0;
            end else begin
              state       <= ST_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
              hrdata_q    <= ahb_hwrite_i ? 32'h0 : rd_fwd;
            end
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= 32'h0;
          end
        end
      endcase
    end
  end

  assign ahb_hreadyout_o = hreadyout_q;
  assign ahb_hresp_o     = hresp_q;
  assign ahb_hrdata_o    = hrdata_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// tb/tb_ahb_reg_slave.sv - self-checking bench for ahb_reg_slave (W=0 and W=2 instances)
module tb_ahb_reg_slave;

  localparam logic [31:0] RV2 = 32'hA5A5_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         hsel, hwrite, hreadyout, hresp;
  logic [31:0]  haddr, hwdata, hrdata;
  logic [2:0]   hsize;
  logic [1:0]   htrans;
  logic [511:0] regs0;

  logic         b_hsel, b_hwrite, b_hreadyout, b_hresp;
  logic [31:0]  b_haddr, b_hwdata, b_hrdata;
  logic [2:0]   b_hsize;
  logic [1:0]   b_htrans;
  logic [511:0] regs2;

  int checks = 0;
  int errors = 0;
  logic [31:0] m [16];

  ahb_reg_slave #(.ADDR_W(12), .NUM_REGS(16), .WAIT_STATES(0), .RESET_VAL(32'h0)) dut0 (
    .clk(clk), .resetn(resetn), .ahb_hsel_i(hsel), .ahb_haddr_i(haddr), .ahb_hwrite_i(hwrite),
    .ahb_hsize_i(hsize), .ahb_htrans_i(htrans), .ahb_hready_i(hreadyout), .ahb_hwdata_i(hwdata),
    .ahb_hreadyout_o(hreadyout), .ahb_hresp_o(hresp), .ahb_hrdata_o(hrdata), .regs_o(regs0));

  ahb_reg_slave #(.ADDR_W(12), .NUM_REGS(16), .WAIT_STATES(2), .RESET_VAL(RV2)) dut2 (
    .clk(clk), .resetn(resetn), .ahb_hsel_i(b_hsel), .ahb_haddr_i(b_haddr), .ahb_hwrite_i(b_hwrite),
    .ahb_hsize_i(b_hsize), .ahb_htrans_i(b_htrans), .ahb_hready_i(b_hreadyout), .ahb_hwdata_i(b_hwdata),
    .ahb_hreadyout_o(b_hreadyout), .ahb_hresp_o(b_hresp), .ahb_hrdata_o(b_hrdata), .regs_o(regs2));

  function automatic logic [511:0] pack_model();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = m[i];
    return p;
  endfunction

  function automatic bit is_bad(input logic [31:0] a, input logic [2:0] s);
    int off;
    off = int'(a[11:0]);
    if (off / 4 >= 16) return 1'b1;
    if (s > 3'd2) return 1'b1;
    return (off % (1 << s)) != 0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int idx, base, n;
    idx  = int'(a[11:2]);
    base = int'(a[1:0]);
    n    = 1 << s;
    for (int k = base; k < base + n; k++) m[idx][8*k +: 8] = wd[8*k +: 8];
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0; hwdata = 32'h0;
    b_hsel = 1'b0; b_htrans = 2'b00; b_hwrite = 1'b0; b_haddr = 32'h0; b_hsize = 3'd0; b_hwdata = 32'h0;
  endtask

  // One non-pipelined transfer on the W=0 instance; control signals dropped in the data phase.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd,
                      output logic [31:0] rd, output logic resp_first, output logic resp_last, output int waits);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size; hwdata = $urandom;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = $urandom; hsize = 3'($urandom); hwdata = wd;
    waits = 0; resp_first = 1'b0;
    @(negedge clk);
    while (hreadyout !== 1'b1 && waits < 16) begin
      if (waits == 0) resp_first = hresp;
      waits++;
      @(negedge clk);
    end
    rd = hrdata; resp_last = hresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus_idle();
    resetn = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    #12;
    checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got rdy=%b resp=%b rdata=%h want 1 0 00000000", hreadyout, hresp, hrdata); end
    checks++; if (regs0 !== 512'h0) begin errors++; $display("FAIL reset_regs0 got %h want 0", regs0); end
    checks++; if (regs2 !== {16{RV2}}) begin errors++; $display("FAIL reset_regs2 got %h want %h", regs2, {16{RV2}}); end
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_w0();
    logic [31:0] rd; logic rf, rl; int w;
    xfer(1'b1, 32'h8000_0004, 3'd2, 32'h1, rd, rf, rl, w);
    model_write(32'h4, 3'd2, 32'h1);
    checks++; if (w !== 0 || rl !== 1'b0) begin errors++; $display("FAIL spec_write waits=%0d resp=%b want 0 0", w, rl); end
    xfer(1'b0, 32'h0000_0004, 3'd2, $urandom, rd, rf, rl, w);
    checks++; if (rd !== 32'h1 || w !== 0 || rl !== 1'b0) begin
      errors++; $display("FAIL spec_read got %h waits=%0d want 00000001 waits=0", rd, w); end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic rf, rl; int w;
    xfer(1'b1, 32'h8, 3'd2, 32'h1122_3344, rd, rf, rl, w); model_write(32'h8, 3'd2, 32'h1122_3344);
    xfer(1'b1, 32'h9, 3'd0, 32'h5566_AB77, rd, rf, rl, w); model_write(32'h9, 3'd0, 32'h5566_AB77);
    xfer(1'b0, 32'h8, 3'd2, 32'h0, rd, rf, rl, w);
    checks++; if (rd !== 32'h1122_AB44) begin errors++; $display("FAIL byte_lane got %h want 1122ab44", rd); end
    xfer(1'b1, 32'hA, 3'd1, 32'hBEEF_9999, rd, rf, rl, w); model_write(32'hA, 3'd1, 32'hBEEF_9999);
    xfer(1'b0, 32'hA, 3'd0, 32'h0, rd, rf, rl, w);
    checks++; if (rd !== 32'hBEEF_AB44) begin errors++; $display("FAIL half_lane got %h want beefab44", rd); end
    checks++; if (regs0 !== pack_model()) begin errors++; $display("FAIL lanes_regs got %h want %h", regs0, pack_model()); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic rf, rl; int w;
    logic [31:0] ea [4] = '{32'h40, 32'h6, 32'h0, 32'h3};
    logic [2:0]  es [4] = '{3'd2, 3'd2, 3'd3, 3'd1};
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, ea[i], es[i], $urandom, rd, rf, rl, w);
      checks++; if (w !== 1 || rf !== 1'b1 || rl !== 1'b1) begin
        errors++; $display("FAIL err_resp case%0d waits=%0d first=%b last=%b want 1 1 1", i, w, rf, rl); end
      checks++; if (regs0 !== pack_model()) begin errors++; $display("FAIL err_nowrite case%0d got %h want %h", i, regs0, pack_model()); end
    end
    for (int i = 0; i < 2; i++) begin
      hsel = (i == 1); htrans = (i == 0) ? 2'b10 : 2'b01; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
      @(posedge clk); #1;
      bus_idle(); hwdata = $urandom;
      @(negedge clk);
      checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
        errors++; $display("FAIL unselected_resp case%0d rdy=%b resp=%b want 1 0", i, hreadyout, hresp); end
      @(posedge clk); #1;
      checks++; if (regs0 !== pack_model()) begin errors++; $display("FAIL unselected_nowrite case%0d got %h want %h", i, regs0, pack_model()); end
    end
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    haddr = 32'h14; hwdata = $urandom;
    @(negedge clk);
    checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL err1 rdy=%b resp=%b want 0 1", hreadyout, hresp); end
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin errors++; $display("FAIL err2 rdy=%b resp=%b want 1 1", hreadyout, hresp); end
    @(posedge clk); #1;
    bus_idle(); hwdata = 32'h7777_1234; model_write(32'h14, 3'd2, 32'h7777_1234);
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL err2_accept rdy=%b resp=%b want 1 0", hreadyout, hresp); end
    @(posedge clk); #1;
    checks++; if (regs0 !== pack_model()) begin errors++; $display("FAIL err2_accept_regs got %h want %h", regs0, pack_model()); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd; logic rf, rl, wr; logic [2:0] s; int w; bit bad;
    for (int n = 0; n < 300; n++) begin
      a = $urandom; a[11:0] = 12'($urandom_range(0, 'h47)); s = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a[1:0] = (s == 3'd0) ? a[1:0] : (s == 3'd1) ? {a[1], 1'b0} : 2'b00;
      wr = 1'($urandom); wd = $urandom; bad = is_bad(a, s);
      xfer(wr, a, s, wd, rd, rf, rl, w);
      checks++; if (w !== (bad ? 1 : 0) || rl !== bad || rf !== bad) begin
        errors++; $display("FAIL rand_resp n=%0d addr=%h size=%0d waits=%0d resp=%b want waits=%0d resp=%b", n, a, s, w, rl, bad ? 1 : 0, bad); end
      if (!bad && wr) model_write(a, s, wd);
      if (!wr || bad) begin
        checks++; if (rd !== ((bad || wr) ? 32'h0 : m[int'(a[11:2])])) begin
          errors++; $display("FAIL rand_rdata n=%0d addr=%h got %h want %h", n, a, rd, bad ? 32'h0 : m[int'(a[11:2])]); end
      end
    end
    checks++; if (regs0 !== pack_model()) begin errors++; $display("FAIL rand_regs got %h want %h", regs0, pack_model()); end
  endtask

  task automatic test_w2();
    int w;
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'hC; b_hwrite = 1'b1; b_hsize = 3'd2;
    @(posedge clk); #1;
    b_hsel = 1'b0; b_htrans = 2'b00; b_hwrite = 1'b0; b_hwdata = 32'hCAFE_F00D;
    w = 0;
    @(negedge clk);
    while (b_hreadyout !== 1'b1 && w < 16) begin w++; @(negedge clk); end
    checks++; if (w !== 2) begin errors++; $display("FAIL w2_write_waits got %0d want 2", w); end
    @(posedge clk); #1;
    checks++; if (regs2[96 +: 32] !== 32'hCAFE_F00D) begin errors++; $display("FAIL w2_reg3 got %h want cafef00d", regs2[96 +: 32]); end
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'hC; b_hwrite = 1'b0; b_hsize = 3'd2;
    @(posedge clk); #1;
    b_hsel = 1'b0; b_htrans = 2'b00; b_hwdata = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (b_hreadyout !== (c == 2) || b_hresp !== 1'b0 || b_hrdata !== ((c == 2) ? 32'hCAFE_F00D : 32'h0)) begin
        errors++; $display("FAIL w2_read cyc%0d rdy=%b resp=%b rdata=%h want %b 0 %h", c, b_hreadyout, b_hresp, b_hrdata,
                           (c == 2), (c == 2) ? 32'hCAFE_F00D : 32'h0); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'hC; b_hwrite = 1'b0; b_hsize = 3'd2;
    @(posedge clk); #1;
    b_hsel = 1'b0; b_htrans = 2'b00;
    checks++; if (b_hreadyout !== 1'b0) begin errors++; $display("FAIL midwait_pre rdy=%b want 0", b_hreadyout); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (b_hreadyout !== 1'b1 || b_hresp !== 1'b0 || b_hrdata !== 32'h0) begin
      errors++; $display("FAIL midwait_reset rdy=%b resp=%b rdata=%h want 1 0 00000000", b_hreadyout, b_hresp, b_hrdata); end
    checks++; if (regs2 !== {16{RV2}} || regs0 !== 512'h0) begin errors++; $display("FAIL midwait_regs r2=%h r0=%h", regs2, regs0); end
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    bus_idle();
    @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic        ow [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] oa [7] = '{32'h14, 32'h18, 32'h18, 32'h19, 32'h19, 32'h14, 32'h3C};
    logic [2:0]  os [7] = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd2, 3'd2};
    logic [31:0] od [7];
    for (int i = 0; i < 7; i++) od[i] = $urandom;
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        hsel = 1'b1; htrans = 2'b10; haddr = oa[i]; hwrite = ow[i]; hsize = os[i];
      end else begin
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      end
      if (i > 0) hwdata = od[i-1];
      @(negedge clk);
      if (i > 0) begin
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
          errors++; $display("FAIL b2b_ready op%0d rdy=%b resp=%b want 1 0", i - 1, hreadyout, hresp); end
        if (!ow[i-1]) begin
          checks++; if (hrdata !== m[int'(oa[i-1][11:2])]) begin
            errors++; $display("FAIL b2b_rdata op%0d got %h want %h", i - 1, hrdata, m[int'(oa[i-1][11:2])]); end
        end else model_write(oa[i-1], os[i-1], od[i-1]);
      end
      @(posedge clk); #1;
    end
    checks++; if (regs0 !== pack_model()) begin errors++; $display("FAIL b2b_regs got %h want %h", regs0, pack_model()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_w0();
    test_lanes();
    test_errors();
    test_random();
    test_w2();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
